speck_key_expander: RTL and testbench
=====================================

Name: speck_key_expander

Overview:
- Parametrised SPECK key expander. Turns one master key of KEY_WORDS words of WORD_W bits into ROUNDS round keys.
- Covers all SPECK variants (32/64 … 128/256) through parameters.
- Streams one round key per cycle over a valid/ready interface to the round datapath. This removes the fixed 128-bit, single-round, multi-cycle update of the previous generation.

Parameters:
- WORD_W, 64, word width n in bits (16, 24, 32, 48, 64).
- KEY_WORDS, 2, key words m (2, 3 or 4).
- ROUNDS, 32, number of round keys emitted; must be ≥ 2.
- ALPHA, 8, right-rotate amount applied to l (7 when WORD_W = 16).
- BETA, 3, left-rotate amount applied to k (2 when WORD_W = 16).
- IDX_W, $clog2(ROUNDS), width of the round index.

Ports:
- clk, input, 1, system clock; all logic updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin expansion; sampled only in IDLE.
- key, input, WORD_W*KEY_WORDS, master key; word 0 (LSBs) is k0, words 1..m-1 are l0..l(m-2).
- busy, output, 1, high from the cycle after start is accepted until the cycle after done.
- rk_valid, output, 1, round key available.
- rk_ready, input, 1, consumer accepts the round key.
- rk_data, output, WORD_W, round key k_i.
- rk_index, output, IDX_W, round number i of rk_data.
- done, output, 1, single-cycle pulse after the last key is accepted.
- state_response, output, 2, current FSM state encoding (debug).

Behaviour:
- Reset values: rk_valid = 0, done = 0, busy = 0, rk_data = 0, rk_index = 0, state = IDLE, all l registers = 0.
- FSM encoding: IDLE = 0, EMIT = 1, DONE = 2.
- IDLE, start = 1:
  - k ← key word 0; l[j] ← key word j+1 for j = 0..m-2; i ← 0.
  - Next state EMIT; first rk_valid appears 1 cycle after start.
- EMIT:
  - rk_valid = 1, rk_data = k, rk_index = i.
  - rk_data and rk_index are held stable while rk_valid && !rk_ready.
- EMIT, handshake (rk_valid && rk_ready) with i < ROUNDS-1, all in one cycle:
  - t = (k + ROR(l[0], ALPHA)) mod 2^WORD_W, XOR zero-extended i.
  - k ← ROL(k, BETA) XOR t.
  - l[j] ← l[j+1] for j < m-2; l[m-2] ← t; i ← i+1.
  - Stay in EMIT, so a continuously ready consumer receives one key per cycle.
- EMIT, handshake with i = ROUNDS-1: rk_valid ← 0, next state DONE.
- DONE: done = 1 for exactly one cycle, busy stays 1, then IDLE.
- start while busy is ignored.
- The key input is sampled only at the start cycle; later key changes have no effect.
- Rotations are modulo WORD_W. All arithmetic wraps at WORD_W bits; no carry out.
- KEY_WORDS = 2: the l array holds a single word; the shift step reduces to l[0] ← t.
- rst asserted mid-expansion: the next cycle is IDLE with reset values; no done pulse; the partial sequence is abandoned.
- rst and start in the same cycle: rst wins.
- rk_ready while rk_valid = 0 has no effect.

Decomposition:
- Package speck_pkg holds:
  - state typedef {IDLE, EMIT, DONE};
  - functions rotr(x, s) and rotl(x, s), parametrised by width;
  - per-variant constants for ALPHA/BETA/ROUNDS (e.g. SPECK128_128_ROUNDS = 32, SPECK32_64_ROUNDS = 22).
- Sub-module speck_ks_round (combinational) computes (k_next, l_new) from (k, l0, i). It is reused later by the on-the-fly encryption core.

Test Plan:
- Speck128/128, key 0x0f0e0d0c0b0a0908_0706050403020100, rk_ready tied high: index 0 data 0x0706050403020100; index 1 data 0x37253b31171d0309. 32 keys on consecutive cycles, all matching the software model. done pulses once, the cycle after index 31 is accepted.
- WORD_W = 16, KEY_WORDS = 4, ROUNDS = 22, ALPHA = 7, BETA = 2, key 0x1918_1110_0908_0100: index 0 data 0x0100; index 1 data 0x1512. All 22 keys match the model.
- Backpressure: rk_ready toggled pseudo-randomly: rk_data/rk_index stable while stalled, no key skipped or duplicated, final sequence identical to the no-stall run.
- Change key and pulse start during EMIT: output sequence unchanged and the second start is ignored; a new start after done produces the new key's sequence.
- Assert rst at index 5 with rk_ready high: next cycle rk_valid = 0, busy = 0, rk_index = 0, no done. A following start restarts at index 0 with the correct k0.
- rst and start in the same cycle: stays IDLE, rk_valid stays 0.

Source files
------------

// File: rtl/speck_key_expander_pkg.sv
// speck_pkg: shared types, per-variant constants and rotate helpers for the
// SPECK key schedule.
//   state_e          - expander FSM state (IDLE=0, EMIT=1, DONE=2)
//   rotr / rotl      - width-parametrised rotates on a 64-bit carrier
//   SPECK*_ROUNDS    - round counts for each standard variant
package speck_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Rotate amounts: 16-bit words use (7,2), all wider words use (8,3).
    localparam int SPECK_ALPHA   = 8;
    localparam int SPECK_BETA    = 3;
    localparam int SPECK16_ALPHA = 7;
    localparam int SPECK16_BETA  = 2;

    localparam int SPECK32_64_ROUNDS   = 22;
    localparam int SPECK48_72_ROUNDS   = 22;
    localparam int SPECK48_96_ROUNDS   = 23;
    localparam int SPECK64_96_ROUNDS   = 26;
    localparam int SPECK64_128_ROUNDS  = 27;
    localparam int SPECK96_96_ROUNDS   = 28;
    localparam int SPECK96_144_ROUNDS  = 29;
    localparam int SPECK128_128_ROUNDS = 32;
    localparam int SPECK128_192_ROUNDS = 33;
    localparam int SPECK128_256_ROUNDS = 34;

    // Low w bits set; w = 64 means all ones.
    function automatic logic [63:0] word_mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Rotates act on the low w bits of x; upper bits of the result are zero.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int s, input int w);
        logic [63:0] xm;
        int          sh;
        xm = x & word_mask(w);
        sh = s % w;
        if (sh == 0) return xm;
        return ((xm >> sh) | (xm << (w - sh))) & word_mask(w);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int s, input int w);
        int sh;
        sh = s % w;
        return rotr(x, (w - sh) % w, w);
    endfunction

endpackage

// File: rtl/speck_key_expander_if.sv
// Round-key stream from the expander to the round datapath.
//   valid/ready - handshake; a key transfers on a cycle where both are high
//   data        - round key k_i
//   index       - round number i of data
interface speck_key_expander_if #(
    parameter int WORD_W = 64,
    parameter int IDX_W  = 5
);
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;
    logic [IDX_W-1:0]  index;

    modport master (output valid, output data, output index, input ready);
    modport slave  (input valid, input data, input index, output ready);
endinterface

// File: rtl/speck_ks_round.sv
// speck_ks_round: one combinational SPECK key-schedule step.
//   k_i      - current round key k_i
//   l0_i     - oldest l word
//   idx_i    - round index i
//   k_next_o - k_(i+1) = ROL(k, BETA) ^ t
//   l_new_o  - t = (k + ROR(l0, ALPHA)) ^ i, the newest l word
module speck_ks_round
    import speck_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int IDX_W  = 5,
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic [WORD_W-1:0] k_i,
    input  logic [WORD_W-1:0] l0_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [WORD_W-1:0] k_next_o,
    output logic [WORD_W-1:0] l_new_o
);
    logic [WORD_W-1:0] l_rot;
    logic [WORD_W-1:0] k_rot;
    logic [WORD_W-1:0] t;

    assign l_rot    = WORD_W'(rotr(64'(l0_i), ALPHA, WORD_W));
    assign k_rot    = WORD_W'(rotl(64'(k_i), BETA, WORD_W));
    // Addition wraps at WORD_W; the carry is intentionally dropped.
    assign t        = (k_i + l_rot) ^ WORD_W'(idx_i);
    assign k_next_o = k_rot ^ t;
    assign l_new_o  = t;
endmodule

// File: rtl/speck_key_expander.sv
// speck_key_expander: expands a KEY_WORDS x WORD_W master key into ROUNDS
// round keys, streamed one per cycle over a valid/ready interface.
//   clk, rst       - clock, synchronous active-high reset
//   start          - begin expansion (only honoured in IDLE)
//   key            - master key; word 0 is k0, words 1..m-1 are l0..l(m-2)
//   busy           - expansion in progress (EMIT or DONE)
//   done           - one-cycle pulse after the last key is accepted
//   state_response - FSM state for debug
//   rk             - round-key stream (master side)
module speck_key_expander
    import speck_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int KEY_WORDS = 2,
    parameter int ROUNDS    = 32,
    parameter int ALPHA     = 8,
    parameter int BETA      = 3,
    parameter int IDX_W     = $clog2(ROUNDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WORD_W*KEY_WORDS-1:0] key,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  state_response,
    speck_key_expander_if.master        rk
);
    localparam int               L_N      = KEY_WORDS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_e                       state_q, state_d;
    logic [WORD_W-1:0]            k_q, k_d;
    logic [L_N-1:0][WORD_W-1:0]   l_q, l_d;
    logic [IDX_W-1:0]             i_q, i_d;

    logic [WORD_W-1:0]            k_next;
    logic [WORD_W-1:0]            t;

    speck_ks_round #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W),
        .ALPHA  (ALPHA),
        .BETA   (BETA)
    ) u_round (
        .k_i      (k_q),
        .l0_i     (l_q[0]),
        .idx_i    (i_q),
        .k_next_o (k_next),
        .l_new_o  (t)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        l_d     = l_q;
        i_d     = i_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    k_d     = key[WORD_W-1:0];
                    for (int j = 0; j < L_N; j++) begin
                        l_d[j] = key[(j+1)*WORD_W +: WORD_W];
                    end
                    i_d = '0;
                end
            end
            EMIT: begin
                // valid is implied by EMIT, so ready alone completes a transfer.
                if (rk.ready) begin
                    if (i_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_next;
                        // l behaves as a FIFO: oldest word consumed, t appended.
                        for (int j = 0; j < L_N - 1; j++) begin
                            l_d[j] = l_q[j+1];
                        end
                        l_d[L_N-1] = t;
                        i_d        = i_q + IDX_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            l_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            l_q     <= l_d;
            i_q     <= i_d;
        end
    end

    assign rk.valid       = (state_q == EMIT);
    assign rk.data        = k_q;
    assign rk.index       = i_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign state_response = state_q;
endmodule

// File: tb/tb_speck_key_expander.sv
module tb_speck_key_expander;
    import speck_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_a, start_b;
    logic [127:0] key_a;
    logic [63:0]  key_b;
    logic         busy_a, done_a, busy_b, done_b;
    logic [1:0]   st_a, st_b;

    speck_key_expander_if #(.WORD_W(64), .IDX_W(5)) rk_a ();
    speck_key_expander_if #(.WORD_W(16), .IDX_W(5)) rk_b ();

    speck_key_expander #(
        .WORD_W(64), .KEY_WORDS(2), .ROUNDS(32), .ALPHA(8), .BETA(3), .IDX_W(5)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key_a), .busy(busy_a),
        .done(done_a), .state_response(st_a), .rk(rk_a)
    );

    speck_key_expander #(
        .WORD_W(16), .KEY_WORDS(4), .ROUNDS(22), .ALPHA(7), .BETA(2), .IDX_W(5)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key_b), .busy(busy_b),
        .done(done_b), .state_response(st_b), .rk(rk_b)
    );

    int          checks = 0;
    int          failures = 0;
    logic [63:0] mk [0:63];
    logic [63:0] got [$];
    logic [63:0] seq_a [$];
    logic [63:0] seq_b [$];

    localparam logic [127:0] KEY_A = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [63:0]  KEY_B = 64'h1918_1110_0908_0100;

    typedef struct {
        string       nm;
        bit          use_b;
        int          idx;
        logic [63:0] data;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference key schedule: k plus a queue of l words, straight from the
    // SPECK definition l[i+m-1] = (k_i + ROR(l_i)) ^ i, k_(i+1) = ROL(k_i) ^ l[i+m-1].
    task automatic gen_model(input logic [255:0] key, input int w, input int m,
                             input int r, input int a, input int b);
        logic [63:0] msk, k, t, l0;
        logic [63:0] lq [$];
        msk = (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
        k = 64'(key) & msk;
        for (int j = 1; j < m; j++) lq.push_back(64'(key >> (j * w)) & msk);
        for (int i = 0; i < r; i++) begin
            mk[i] = k;
            l0 = lq.pop_front();
            t = ((k + (((l0 >> a) | (l0 << (w - a))) & msk)) & msk) ^ 64'(i);
            k = (((k << b) | (k >> (w - b))) & msk) ^ t;
            lq.push_back(t);
        end
    endtask

    // Runs one expansion on the 128/128 instance. stall_pct sets how often
    // ready is dropped; disturb re-pulses start with a different key mid-run.
    task automatic expand_a(input logic [127:0] kin, input int stall_pct,
                            input bit disturb, input string tag);
        int          cyc, extra_done, stall_err, idx_err;
        bit          stalled;
        logic [63:0] pd;
        logic [4:0]  pi;
        got.delete();
        key_a = kin;
        start_a = 1'b1;
        rk_a.ready = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk({tag, "_first_valid"}, 64'(rk_a.valid), 64'd1);
        chk({tag, "_busy"}, 64'(busy_a), 64'd1);
        cyc = 0; extra_done = 0; stall_err = 0; idx_err = 0; stalled = 1'b0;
        pd = '0; pi = '0;
        while (got.size() < 32 && cyc < 1000) begin
            if (done_a) extra_done++;
            if (stalled && (rk_a.data !== pd || rk_a.index !== pi)) stall_err++;
            if (disturb && cyc == 3) begin
                key_a = ~kin;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            rk_a.ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            if (rk_a.valid && rk_a.ready) begin
                if (rk_a.index !== 5'(got.size())) idx_err++;
                got.push_back(rk_a.data);
            end
            stalled = rk_a.valid && !rk_a.ready;
            pd = rk_a.data;
            pi = rk_a.index;
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        rk_a.ready = 1'b0;
        chk({tag, "_key_count"}, 64'(got.size()), 64'd32);
        chk({tag, "_early_done"}, 64'(extra_done), 64'd0);
        chk({tag, "_stall_hold_err"}, 64'(stall_err), 64'd0);
        chk({tag, "_index_err"}, 64'(idx_err), 64'd0);
        if (stall_pct == 0) chk({tag, "_cycles"}, 64'(cyc), 64'd32);
        chk({tag, "_done_pulse"}, 64'(done_a), 64'd1);
        chk({tag, "_valid_in_done"}, 64'(rk_a.valid), 64'd0);
        chk({tag, "_busy_in_done"}, 64'(busy_a), 64'd1);
        chk({tag, "_state_done"}, 64'(st_a), 64'd2);
        @(posedge clk); #1;
        chk({tag, "_done_cleared"}, 64'(done_a), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_idle_state"}, 64'(st_a), 64'd0);
        gen_model({128'd0, kin}, 64, 2, 32, 8, 3);
        for (int i = 0; i < got.size(); i++) chk($sformatf("%s_key%0d", tag, i), got[i], mk[i]);
    endtask

    // Runs one expansion on the 32/64 instance with ready held high.
    task automatic expand_b(input logic [63:0] kin, input string tag);
        int idx_err;
        got.delete();
        idx_err = 0;
        key_b = kin;
        start_b = 1'b1;
        rk_b.ready = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (rk_b.valid) begin
                if (rk_b.index !== 5'(got.size())) idx_err++;
                got.push_back(64'(rk_b.data));
            end
            @(posedge clk); #1;
        end
        rk_b.ready = 1'b0;
        chk({tag, "_key_count"}, 64'(got.size()), 64'd22);
        chk({tag, "_index_err"}, 64'(idx_err), 64'd0);
        chk({tag, "_done_pulse"}, 64'(done_b), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 64'(busy_b), 64'd0);
        gen_model({192'd0, kin}, 16, 4, 22, 7, 2);
        for (int i = 0; i < got.size(); i++) chk($sformatf("%s_key%0d", tag, i), got[i], mk[i]);
    endtask

    initial begin
        vec_t vt [4];
        int   c;
        vt[0] = '{nm: "s128_idx0", use_b: 1'b0, idx: 0,  data: 64'h0706050403020100};
        vt[1] = '{nm: "s128_idx1", use_b: 1'b0, idx: 1,  data: 64'h37253b31171d0309};
        vt[2] = '{nm: "s32_idx0",  use_b: 1'b1, idx: 0,  data: 64'h0100};
        vt[3] = '{nm: "s32_idx1",  use_b: 1'b1, idx: 1,  data: 64'h1512};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
        rk_a.ready = 1'b0; rk_b.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rk_a.valid), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_data", rk_a.data, 64'd0);
        chk("rst_index", 64'(rk_a.index), 64'd0);
        chk("rst_state", 64'(st_a), 64'd0);
        chk("rst_valid_b", 64'(rk_b.valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        expand_a(KEY_A, 0, 1'b0, "base");
        seq_a = got;
        expand_b(KEY_B, "s32");
        seq_b = got;

        foreach (vt[v]) begin
            if (vt[v].use_b) chk(vt[v].nm, (vt[v].idx < seq_b.size()) ? seq_b[vt[v].idx] : 64'hx, vt[v].data);
            else             chk(vt[v].nm, (vt[v].idx < seq_a.size()) ? seq_a[vt[v].idx] : 64'hx, vt[v].data);
        end

        expand_a(KEY_A, 40, 1'b0, "stall");
        expand_a(KEY_A, 0, 1'b1, "disturb");
        expand_a(~KEY_A, 0, 1'b0, "newkey");

        // Reset at index 5 with a ready consumer.
        key_a = KEY_A; start_a = 1'b1; rk_a.ready = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0; rk_a.ready = 1'b1;
        c = 0;
        while (!(rk_a.valid && rk_a.index == 5'd5) && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("midrst_reached_idx5", 64'(rk_a.index), 64'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rk_a.ready = 1'b0;
        chk("midrst_valid", 64'(rk_a.valid), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_index", 64'(rk_a.index), 64'd0);
        chk("midrst_done", 64'(done_a), 64'd0);
        chk("midrst_state", 64'(st_a), 64'd0);
        @(posedge clk); #1;
        chk("midrst_no_late_done", 64'(done_a), 64'd0);
        expand_a(KEY_A, 0, 1'b0, "after_rst");

        // rst and start together: reset dominates.
        rst = 1'b1; start_a = 1'b1; key_a = KEY_A;
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0;
        chk("rst_start_state", 64'(st_a), 64'd0);
        chk("rst_start_valid", 64'(rk_a.valid), 64'd0);
        @(posedge clk); #1;
        chk("rst_start_valid2", 64'(rk_a.valid), 64'd0);
        chk("rst_start_busy2", 64'(busy_a), 64'd0);

        for (int r = 0; r < 3; r++)
            expand_a({$urandom, $urandom, $urandom, $urandom}, 30, 1'b0, $sformatf("rand_a%0d", r));
        for (int r = 0; r < 2; r++)
            expand_b({$urandom, $urandom}, $sformatf("rand_b%0d", r));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
